// File: rtl/dma_reader_pkg.sv
// Shared definitions for the bus DMA engines: word width, command layout,
// block geometry and the engine state encoding.
package dma_reader_pkg;

    localparam int unsigned WORD_SIZE = 16;
    localparam int unsigned CMD_W     = 2 * WORD_SIZE + 1;
    localparam int unsigned BLK_WORDS = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned OFS_W     = 2;
    localparam int unsigned MAX_LEN   = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned BLK_W     = BLK_WORDS * WORD_SIZE;

    // CPU command word: valid at bit 32, base address [31:16], length [15:0]
    typedef struct packed {
        logic                 valid;
        logic [WORD_SIZE-1:0] base;
        logic [WORD_SIZE-1:0] len;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PUSH,
        ST_REST,
        ST_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] clamp_len(input logic [WORD_SIZE-1:0] len);
        return (len > WORD_SIZE'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dma_block_packer.sv
// Four-word block buffer with zero padding of unfilled slots, plus the
// odata/offset/ovalid register slice handshaking with the device.
module dma_block_packer
    import dma_reader_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [WORD_SIZE-1:0] wr_data,
    input  logic                 load,
    input  logic [OFS_W-1:0]     load_offset,
    input  logic                 oready,
    output logic [BLK_W-1:0]     odata,
    output logic [OFS_W-1:0]     offset,
    output logic                 ovalid
);

    logic [WORD_SIZE-1:0] word_buf [BLK_WORDS];
    logic [BLK_W-1:0]     blk_c;

    // Block image: buffered words below the incoming slot, incoming word, zeros above
    always_comb begin
        blk_c = '0;
        for (int i = 0; i < int'(BLK_WORDS); i++) begin
            if (IDX_W'(i) == wr_idx) begin
                blk_c[i*WORD_SIZE +: WORD_SIZE] = wr_data;
            end else if (IDX_W'(i) < wr_idx) begin
                blk_c[i*WORD_SIZE +: WORD_SIZE] = word_buf[IDX_W'(i)];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < int'(BLK_WORDS); i++) begin
                word_buf[IDX_W'(i)] <= '0;
            end
            odata  <= '0;
            offset <= '0;
            ovalid <= 1'b0;
        end else begin
            if (wr_en) begin
                word_buf[wr_idx] <= wr_data;
            end
            if (load) begin
                odata  <= blk_c;
                offset <= load_offset;
                ovalid <= 1'b1;
            end else if (ovalid && oready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dma_reader.sv
// Memory-to-device DMA: fetches words over the shared bus and hands 4-word
// blocks to the device. Define CYCLE_STEAL_EN to release the bus between blocks.
module dma_reader
    import dma_reader_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [CMD_W-1:0]     cmd,
    input  logic                 BG,
    output logic                 BR,
    output logic                 READ,
    output logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 mem_ack,
    output logic [BLK_W-1:0]     odata,
    output logic [OFS_W-1:0]     offset,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 interrupt
);

    state_t               state;
    cmd_t                 cmd_s;
    logic [WORD_SIZE-1:0] base;
    logic [CNT_W-1:0]     len;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     next_count;
    logic                 accept;
    logic                 last_word;
    logic                 blk_end;

    assign cmd_s      = cmd_t'(cmd);
    assign accept     = (state == ST_FETCH) && BG && mem_ack;
    assign next_count = count + CNT_W'(1);
    assign last_word  = (next_count == len);
    assign blk_end    = accept && ((next_count[IDX_W-1:0] == '0) || last_word);

    // Bus drivers float whenever the CPU owns the bus
    assign READ = BG ? (state == ST_FETCH) : 1'bz;
    assign addr = BG ? WORD_SIZE'(base + WORD_SIZE'(count)) : {WORD_SIZE{1'bz}};

    dma_block_packer u_packer (
        .CLK         (CLK),
        .RESET       (RESET),
        .wr_en       (accept),
        .wr_idx      (count[IDX_W-1:0]),
        .wr_data     (mem_data),
        .load        (blk_end),
        .load_offset (count[IDX_W+OFS_W-1:IDX_W]),
        .oready      (oready),
        .odata       (odata),
        .offset      (offset),
        .ovalid      (ovalid)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            BR        <= 1'b0;
            interrupt <= 1'b0;
            base      <= '0;
            len       <= '0;
            count     <= '0;
        end else begin
            interrupt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_s.valid) begin
                        base  <= cmd_s.base;
                        len   <= clamp_len(cmd_s.len);
                        count <= '0;
                        if (cmd_s.len == '0) begin
                            interrupt <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            BR    <= 1'b1;
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (accept) begin
                        count <= next_count;
                        if (blk_end) begin
                            state <= ST_PUSH;
`ifdef CYCLE_STEAL_EN
                            if (!last_word) begin
                                BR <= 1'b0;
                            end
`endif
                        end
                    end
                end
                ST_PUSH: begin
                    if (ovalid && oready) begin
                        if (count == len) begin
                            BR        <= 1'b0;
                            interrupt <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
`ifdef CYCLE_STEAL_EN
                            state <= ST_REST;
`else
                            state <= ST_FETCH;
`endif
                        end
                    end
                end
                ST_REST: begin
                    BR    <= 1'b1;
                    state <= ST_FETCH;
                end
                ST_DONE: begin
                    BR    <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    BR    <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_reader.sv
// Directed bench for dma_reader: block table with hand-computed images plus
// stall, zero-length, reset-abort and bus-release sequences.
module tb_dma_reader;

    logic        CLK;
    logic        RESET;
    logic [32:0] cmd;
    logic        BG;
    logic        BR;
    wire         READ;
    wire  [15:0] addr;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [63:0] odata;
    logic [1:0]  offset;
    logic        ovalid;
    logic        oready;
    logic        interrupt;

    int          n_vec;
    int          n_bad;
    int          n_reads;
    logic [15:0] exp_addr;
    logic        bg_pend;

    dma_reader dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .cmd       (cmd),
        .BG        (BG),
        .BR        (BR),
        .READ      (READ),
        .addr      (addr),
        .mem_data  (mem_data),
        .mem_ack   (mem_ack),
        .odata     (odata),
        .offset    (offset),
        .ovalid    (ovalid),
        .oready    (oready),
        .interrupt (interrupt)
    );

    // Memory returns its own address as data
    assign mem_data = addr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic        first;
        logic        last;
        logic [63:0] exp_odata;
        logic [1:0]  exp_offset;
        int          exp_reads;
    } blk_vec_t;

    blk_vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: grant follows request by a cycle; every read beat is address-checked
    task automatic tick();
        @(posedge CLK);
        #1;
        BG      = bg_pend;
        bg_pend = BR;
        #1;
        if (READ === 1'b1) begin
            check("read_addr", 64'(addr), 64'(exp_addr));
            exp_addr = exp_addr + 16'd1;
            n_reads++;
        end
        if (BG == 1'b0) begin
            check("read_without_grant", 64'(READ === 1'b1), 64'd0);
        end
    endtask

    task automatic send_cmd(input logic [15:0] base, input logic [15:0] len);
        exp_addr = base;
        n_reads  = 0;
        cmd      = {1'b1, base, len};
        tick();
        cmd      = '0;
    endtask

    task automatic wait_ovalid();
        for (int i = 0; i < 200 && ovalid !== 1'b1; i++) begin
            tick();
        end
        check("ovalid_timeout", 64'(ovalid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int low;
        logic got_int;

        n_vec    = 0;
        n_bad    = 0;
        n_reads  = 0;
        exp_addr = '0;
        bg_pend  = 1'b0;
        RESET    = 1'b1;
        cmd      = '0;
        BG       = 1'b0;
        mem_ack  = 1'b1;
        oready   = 1'b1;

        vecs[0] = '{16'h01F4, 16'd12, 1'b1, 1'b0, 64'h01F7_01F6_01F5_01F4, 2'd0, 0};
        vecs[1] = '{16'h01F4, 16'd12, 1'b0, 1'b0, 64'h01FB_01FA_01F9_01F8, 2'd1, 0};
        vecs[2] = '{16'h01F4, 16'd12, 1'b0, 1'b1, 64'h01FF_01FE_01FD_01FC, 2'd2, 12};
        vecs[3] = '{16'h0100, 16'd6,  1'b1, 1'b0, 64'h0103_0102_0101_0100, 2'd0, 0};
        vecs[4] = '{16'h0100, 16'd6,  1'b0, 1'b1, 64'h0000_0000_0105_0104, 2'd1, 6};
        vecs[5] = '{16'hFFFD, 16'd4,  1'b1, 1'b1, 64'h0000_FFFF_FFFE_FFFD, 2'd0, 4};
        vecs[6] = '{16'h2000, 16'd40, 1'b1, 1'b0, 64'h2003_2002_2001_2000, 2'd0, 0};
        vecs[7] = '{16'h2000, 16'd40, 1'b0, 1'b0, 64'h2007_2006_2005_2004, 2'd1, 0};
        vecs[8] = '{16'h2000, 16'd40, 1'b0, 1'b0, 64'h200B_200A_2009_2008, 2'd2, 0};
        vecs[9] = '{16'h2000, 16'd40, 1'b0, 1'b1, 64'h200F_200E_200D_200C, 2'd3, 16};

        tick();
        tick();
        check("rst_BR", 64'(BR), 64'd0);
        check("rst_ovalid", 64'(ovalid), 64'd0);
        check("rst_interrupt", 64'(interrupt), 64'd0);
        check("rst_odata", odata, 64'd0);
        check("rst_offset", 64'(offset), 64'd0);
        RESET = 1'b0;
        tick();

        // Block table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].first) send_cmd(vecs[i].base, vecs[i].len);
            wait_ovalid();
            check("blk_odata", odata, vecs[i].exp_odata);
            check("blk_offset", 64'(offset), 64'(vecs[i].exp_offset));
            tick();
            if (vecs[i].last) begin
                check("done_interrupt", 64'(interrupt), 64'd1);
                check("done_BR", 64'(BR), 64'd0);
                check("done_ovalid", 64'(ovalid), 64'd0);
                check("done_reads", 64'(n_reads), 64'(vecs[i].exp_reads));
                tick();
                check("int_pulse_end", 64'(interrupt), 64'd0);
            end
        end

        // Device stalls: block held stable, no bus reads, count frozen
        oready = 1'b0;
        send_cmd(16'h0400, 16'd4);
        wait_ovalid();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_ovalid", 64'(ovalid), 64'd1);
            check("stall_odata", odata, 64'h0403_0402_0401_0400);
            check("stall_offset", 64'(offset), 64'd0);
            check("stall_no_read", 64'(READ === 1'b1), 64'd0);
            check("stall_addr", 64'(addr), 64'h0404);
        end
        oready = 1'b1;
        tick();
        check("stall_interrupt", 64'(interrupt), 64'd1);
        check("stall_reads", 64'(n_reads), 64'd4);
        tick();

        // Zero-length command
        send_cmd(16'h0500, 16'd0);
        check("len0_interrupt", 64'(interrupt), 64'd1);
        check("len0_BR", 64'(BR), 64'd0);
        tick();
        check("len0_int_end", 64'(interrupt), 64'd0);
        check("len0_BR_after", 64'(BR), 64'd0);
        check("len0_reads", 64'(n_reads), 64'd0);

        // Reset mid-fetch, then a fresh transfer restarts from word 0
        send_cmd(16'h0600, 16'd8);
        for (int i = 0; i < 50 && n_reads < 3; i++) begin
            tick();
        end
        check("abort_reads_reached", 64'(n_reads >= 3), 64'd1);
        tick();
        RESET = 1'b1;
        #1;
        check("abort_BR", 64'(BR), 64'd0);
        check("abort_ovalid", 64'(ovalid), 64'd0);
        check("abort_interrupt", 64'(interrupt), 64'd0);
        tick();
        check("abort_no_int", 64'(interrupt), 64'd0);
        tick();
        RESET = 1'b0;
        tick();
        send_cmd(16'h0700, 16'd2);
        wait_ovalid();
        check("restart_odata", odata, 64'h0000_0000_0701_0700);
        check("restart_offset", 64'(offset), 64'd0);
        tick();
        check("restart_interrupt", 64'(interrupt), 64'd1);
        check("restart_reads", 64'(n_reads), 64'd2);
        tick();

        // Bus request profile over a two-block transfer
        send_cmd(16'h0800, 16'd8);
        low     = 0;
        got_int = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (interrupt === 1'b1) begin
                got_int = 1'b1;
                break;
            end
            if (BR == 1'b0) low++;
            tick();
        end
        check("steal_interrupt", 64'(got_int), 64'd1);
`ifdef CYCLE_STEAL_EN
        check("steal_BR_low_cycles", 64'(low), 64'd2);
`else
        check("burst_BR_low_cycles", 64'(low), 64'd0);
`endif
        check("steal_reads", 64'(n_reads), 64'd8);
        tick();
        check("steal_int_end", 64'(interrupt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
